// File: rtl/butterfly_pkg.sv
// Shared constants and helpers for the pipelined complex butterfly array.
// MAXW bounds the word width accepted by sat_trunc (N must be below MAXW).
package butterfly_pkg;

    localparam int N_DEF = 32;
    localparam int D_DEF = 16;
    localparam int LAT   = 3;
    localparam int MAXW  = 64;

    function automatic int lane_lo(input int lane, input int n);
        return lane * n;
    endfunction

    // Narrow an (n+1)-bit sum (sign-extended to MAXW+1) to n bits; clamps when sat is set.
    function automatic logic [MAXW-1:0] sat_trunc(input logic [MAXW:0] sum,
                                                   input logic [6:0]    n,
                                                   input logic          sat);
        logic            ovf;
        logic [MAXW-1:0] mx;
        ovf = sum[n] ^ sum[n - 7'd1];
        mx  = ~({MAXW{1'b1}} << (n - 7'd1));
        if (sat && ovf)
            return sum[n] ? ~mx : mx;
        return sum[MAXW-1:0];
    endfunction

endpackage

// File: rtl/butterfly_pipe_lane.sv
// One butterfly lane: S1 products, S2 twiddled b, S3 sum/difference with scale and saturation.
// Every stage register advances only when en_i is high.
module bfly_lane
    import butterfly_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int D    = D_DEF,
    parameter int MULT = 1,
    parameter int SAT  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic                scale_i,
    input  logic signed [N-1:0] ar_i,
    input  logic signed [N-1:0] ac_i,
    input  logic signed [N-1:0] br_i,
    input  logic signed [N-1:0] bc_i,
    input  logic signed [N-1:0] wr_i,
    input  logic signed [N-1:0] wc_i,
    output logic        [N-1:0] cr_o,
    output logic        [N-1:0] cc_o,
    output logic        [N-1:0] dr_o,
    output logic        [N-1:0] dc_o,
    output logic                ovf_o
);

    logic signed [2*N-1:0] p_rr_d, p_cc_d, p_rc_d, p_cr_d;
    logic signed [2*N-1:0] p_rr_q, p_cc_q, p_rc_q, p_cr_q;
    logic signed [N-1:0]   a1r_q, a1c_q, b1r_q, b1c_q;
    logic                  sc1_q;

    logic signed [2*N-1:0] tr_full, tc_full;
    logic signed [N-1:0]   t2r_d, t2c_d;
    logic signed [N-1:0]   a2r_q, a2c_q, t2r_q, t2c_q;
    logic                  sc2_q;

    logic [N:0]   s_cr, s_cc, s_dr, s_dc;
    logic [N:0]   r_cr, r_cc, r_dr, r_dc;
    logic [N-1:0] cr_q, cc_q, dr_q, dc_q;
    logic         ovf_d, ovf_q;

    // Returns {overflow, result}; the halved sum always fits, so it never flags.
    function automatic logic [N:0] post_sum(input logic [N:0] sum, input logic scl);
        logic ov;
        ov = sum[N] ^ sum[N-1];
        if (scl)
            return {1'b0, sum[N:1]};
        return {ov, N'(sat_trunc({{(MAXW-N){sum[N]}}, sum}, 7'(N), SAT != 0))};
    endfunction

    assign p_rr_d = (2*N)'(br_i) * (2*N)'(wr_i);
    assign p_cc_d = (2*N)'(bc_i) * (2*N)'(wc_i);
    assign p_rc_d = (2*N)'(br_i) * (2*N)'(wc_i);
    assign p_cr_d = (2*N)'(bc_i) * (2*N)'(wr_i);

    assign tr_full = p_rr_q - p_cc_q;
    assign tc_full = p_rc_q + p_cr_q;
    assign t2r_d   = (MULT != 0) ? N'(tr_full >>> D) : b1r_q;
    assign t2c_d   = (MULT != 0) ? N'(tc_full >>> D) : b1c_q;

    assign s_cr = {a2r_q[N-1], a2r_q} + {t2r_q[N-1], t2r_q};
    assign s_cc = {a2c_q[N-1], a2c_q} + {t2c_q[N-1], t2c_q};
    assign s_dr = {a2r_q[N-1], a2r_q} - {t2r_q[N-1], t2r_q};
    assign s_dc = {a2c_q[N-1], a2c_q} - {t2c_q[N-1], t2c_q};

    assign r_cr  = post_sum(s_cr, sc2_q);
    assign r_cc  = post_sum(s_cc, sc2_q);
    assign r_dr  = post_sum(s_dr, sc2_q);
    assign r_dc  = post_sum(s_dc, sc2_q);
    assign ovf_d = r_cr[N] | r_cc[N] | r_dr[N] | r_dc[N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_rr_q <= '0; p_cc_q <= '0; p_rc_q <= '0; p_cr_q <= '0;
            a1r_q  <= '0; a1c_q  <= '0; b1r_q  <= '0; b1c_q  <= '0;
            sc1_q  <= 1'b0;
            a2r_q  <= '0; a2c_q  <= '0; t2r_q  <= '0; t2c_q  <= '0;
            sc2_q  <= 1'b0;
            cr_q   <= '0; cc_q   <= '0; dr_q   <= '0; dc_q   <= '0;
            ovf_q  <= 1'b0;
        end else if (en_i) begin
            p_rr_q <= p_rr_d; p_cc_q <= p_cc_d; p_rc_q <= p_rc_d; p_cr_q <= p_cr_d;
            a1r_q  <= ar_i;   a1c_q  <= ac_i;   b1r_q  <= br_i;   b1c_q  <= bc_i;
            sc1_q  <= scale_i;
            a2r_q  <= a1r_q;  a2c_q  <= a1c_q;  t2r_q  <= t2r_d;  t2c_q  <= t2c_d;
            sc2_q  <= sc1_q;
            cr_q   <= r_cr[N-1:0]; cc_q <= r_cc[N-1:0];
            dr_q   <= r_dr[N-1:0]; dc_q <= r_dc[N-1:0];
            ovf_q  <= ovf_d;
        end
    end

    assign cr_o  = cr_q;
    assign cc_o  = cc_q;
    assign dr_o  = dr_q;
    assign dc_o  = dc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/butterfly_pipe.sv
// CH-lane radix-2 butterfly, three register stages, one transaction per cycle.
// Handshake: a transfer happens on any edge where val & rdy; the whole pipe stalls only when the output is held.
module butterfly_pipe
    import butterfly_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int D    = D_DEF,
    parameter int CH   = 1,
    parameter int MULT = 1,
    parameter int SAT  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            recv_val,
    output logic            recv_rdy,
    input  logic            scale,
    input  logic [CH*N-1:0] ar,
    input  logic [CH*N-1:0] ac,
    input  logic [CH*N-1:0] br,
    input  logic [CH*N-1:0] bc,
    input  logic [CH*N-1:0] wr,
    input  logic [CH*N-1:0] wc,
    output logic            send_val,
    input  logic            send_rdy,
    output logic [CH*N-1:0] cr,
    output logic [CH*N-1:0] cc,
    output logic [CH*N-1:0] dr,
    output logic [CH*N-1:0] dc,
    output logic [CH-1:0]   ovf
);

    logic           en;
    logic [LAT-1:0] vld_d, vld_q;

    assign en       = ~vld_q[LAT-1] | send_rdy;
    assign recv_rdy = en;
    assign send_val = vld_q[LAT-1];

    always_comb begin
        vld_d = {vld_q[LAT-2:0], recv_val};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_q <= '0;
        else if (en)
            vld_q <= vld_d;
    end

    for (genvar i = 0; i < CH; i++) begin : g_lane
        bfly_lane #(
            .N    (N),
            .D    (D),
            .MULT (MULT),
            .SAT  (SAT)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .en_i    (en),
            .scale_i (scale),
            .ar_i    (ar[lane_lo(i, N) +: N]),
            .ac_i    (ac[lane_lo(i, N) +: N]),
            .br_i    (br[lane_lo(i, N) +: N]),
            .bc_i    (bc[lane_lo(i, N) +: N]),
            .wr_i    (wr[lane_lo(i, N) +: N]),
            .wc_i    (wc[lane_lo(i, N) +: N]),
            .cr_o    (cr[lane_lo(i, N) +: N]),
            .cc_o    (cc[lane_lo(i, N) +: N]),
            .dr_o    (dr[lane_lo(i, N) +: N]),
            .dc_o    (dc[lane_lo(i, N) +: N]),
            .ovf_o   (ovf[i])
        );
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe: a saturating single lane, a wrapping single lane,
// and a four-lane pass-through instance sharing the same handshake controls.
module tb_butterfly_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         recv_val, send_rdy, scale;
    logic [31:0]  ar, ac, br, bc, wr, wc;
    logic         recv_rdy, send_val;
    logic [31:0]  cr, cc, dr, dc;
    logic [0:0]   ovf;
    logic         w_recv_rdy, w_send_val;
    logic [31:0]  w_cr, w_cc, w_dr, w_dc;
    logic [0:0]   w_ovf;
    logic [127:0] q_ar, q_ac, q_br, q_bc, q_wr, q_wc;
    logic         q_recv_rdy, q_send_val;
    logic [127:0] q_cr, q_cc, q_dr, q_dc;
    logic [3:0]   q_ovf;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    butterfly_pipe u_dut (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy), .scale(scale),
        .ar(ar), .ac(ac), .br(br), .bc(bc), .wr(wr), .wc(wc),
        .send_val(send_val), .send_rdy(send_rdy),
        .cr(cr), .cc(cc), .dr(dr), .dc(dc), .ovf(ovf)
    );

    butterfly_pipe #(.SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(w_recv_rdy), .scale(scale),
        .ar(ar), .ac(ac), .br(br), .bc(bc), .wr(wr), .wc(wc),
        .send_val(w_send_val), .send_rdy(send_rdy),
        .cr(w_cr), .cc(w_cc), .dr(w_dr), .dc(w_dc), .ovf(w_ovf)
    );

    butterfly_pipe #(.CH(4), .MULT(0)) u_quad (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(q_recv_rdy), .scale(scale),
        .ar(q_ar), .ac(q_ac), .br(q_br), .bc(q_bc), .wr(q_wr), .wc(q_wc),
        .send_val(q_send_val), .send_rdy(send_rdy),
        .cr(q_cr), .cc(q_cc), .dr(q_dr), .dc(q_dc), .ovf(q_ovf)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] a_r, input logic [31:0] a_c,
                          input logic [31:0] b_r, input logic [31:0] b_c,
                          input logic [31:0] w_r, input logic [31:0] w_c,
                          input logic s);
        ar = a_r; ac = a_c; br = b_r; bc = b_c; wr = w_r; wc = w_c; scale = s;
    endtask

    // Present one transaction at a negedge; return edges until send_val rises (accept edge = 1).
    task automatic one_txn(output int lat);
        recv_val = 1'b1;
        send_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        recv_val = 1'b0;
        lat = 1;
        while (!send_val && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic idle(input int n);
        recv_val = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    function automatic logic [63:0] stream_exp(input int i);
        logic [31:0] a, b;
        a = 32'(i) << 16;
        b = 32'(i) << 8;
        return {a + b, a - b};
    endfunction

    task automatic drive_stream(input int i);
        set_in(32'(i) << 16, 32'h0, 32'(i) << 8, 32'h0, 32'h0001_0000, 32'h0, 1'b0);
    endtask

    // Called at a negedge with inputs driven; scores what the next posedge transfers.
    task automatic cycle(input int idx, output bit acc, output bit emit);
        logic [63:0] e;
        #1;
        acc  = recv_val && recv_rdy;
        emit = send_val && send_rdy;
        if (send_val && !send_rdy)
            check("stall_recv_rdy", {127'b0, recv_rdy}, 128'd0);
        if (acc)
            exp_q.push_back(stream_exp(idx));
        if (emit) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL stream_extra: observed output %h expected none", {cr, dr});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("stream_data", {64'b0, cr, dr}, {64'b0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat, idx, got, c, first, last;
        bit acc, emit;

        reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b1;
        set_in(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        q_ar = '0; q_ac = '0; q_br = '0; q_bc = '0; q_wr = '0; q_wc = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_send_val", {127'b0, send_val}, 128'd0);
        check("rst_recv_rdy", {127'b0, recv_rdy}, 128'd1);
        check("rst_cr_dr", {64'b0, cr, dr}, 128'd0);
        check("rst_ovf", {127'b0, ovf}, 128'd0);
        @(negedge clk);

        // a=1, b=1, w=1
        set_in(32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0, 1'b0);
        one_txn(lat);
        check("t1_latency", 128'(lat), 128'd3);
        check("t1_cr_cc_dr_dc", {cr, cc, dr, dc}, {32'h0002_0000, 32'h0, 32'h0, 32'h0});
        check("t1_ovf", {127'b0, ovf}, 128'd0);

        // a=1+1j, b=2, w=j
        set_in(32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0, 32'h0, 32'h0001_0000, 1'b0);
        one_txn(lat);
        check("t2_latency", 128'(lat), 128'd3);
        check("t2_cr_cc_dr_dc", {cr, cc, dr, dc},
              {32'h0001_0000, 32'h0003_0000, 32'h0001_0000, 32'hFFFF_0000});

        // b = -2^-16, w = 0.5: the product rounds toward -inf to -1 LSB
        set_in(32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_8000, 32'h0, 1'b0);
        one_txn(lat);
        check("trunc_cr_dr", {64'b0, cr, dr}, {64'b0, 32'hFFFF_FFFF, 32'h0000_0001});

        // a=b=max, w=1: saturate, wrap, and halve
        set_in(32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h0, 32'h0001_0000, 32'h0, 1'b0);
        one_txn(lat);
        check("t3_sat_cr_dr", {64'b0, cr, dr}, {64'b0, 32'h7FFF_FFFF, 32'h0});
        check("t3_sat_ovf", {127'b0, ovf}, 128'd1);
        check("t3_wrap_cr", {96'b0, w_cr}, {96'b0, 32'hFFFF_FFFE});
        check("t3_wrap_ovf", {127'b0, w_ovf}, 128'd1);
        set_in(32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h0, 32'h0001_0000, 32'h0, 1'b1);
        one_txn(lat);
        check("t3_scale_cr_dr", {64'b0, cr, dr}, {64'b0, 32'h7FFF_FFFF, 32'h0});
        check("t3_scale_ovf", {127'b0, ovf}, 128'd0);
        idle(1);

        // 16 back-to-back with the sink always ready
        idx = 0; got = 0; c = 0; first = -1; last = -1;
        while (got < 16 && c < 80) begin
            recv_val = (idx < 16);
            send_rdy = 1'b1;
            drive_stream(idx + 1);
            cycle(idx + 1, acc, emit);
            if (acc) idx++;
            if (emit) begin
                got++;
                if (first < 0) first = c;
                last = c;
            end
            c++;
        end
        check("t4_count", 128'(got), 128'd16);
        check("t4_consecutive", 128'(last - first), 128'd15);
        check("t4_queue_empty", 128'(exp_q.size()), 128'd0);

        // 8 inputs with the sink stalled for cycles 4..8
        idx = 0; got = 0; c = 0;
        while ((got < 8 || idx < 8) && c < 80) begin
            recv_val = (idx < 8);
            send_rdy = !(c >= 4 && c <= 8);
            drive_stream(idx + 40);
            cycle(idx + 40, acc, emit);
            if (acc) idx++;
            if (emit) got++;
            c++;
        end
        check("t5_count", 128'(got), 128'd8);
        check("t5_queue_empty", 128'(exp_q.size()), 128'd0);

        // Reset pulsed between edges while outputs are pending
        idx = 0; send_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            recv_val = 1'b1;
            drive_stream(idx + 100);
            cycle(idx + 100, acc, emit);
            if (acc) idx++;
        end
        check("t6_pre_reset_val", {127'b0, send_val}, 128'd1);
        recv_val = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("t6_reset_send_val", {126'b0, send_val, q_send_val}, 128'd0);
        check("t6_reset_data", {64'b0, cr, dr}, 128'd0);
        #1 reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("t6_post_recv_rdy", {127'b0, recv_rdy}, 128'd1);

        set_in(32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0, 1'b0);
        q_ar = {32'h7FFF_FFFF, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        q_ac = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        q_br = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        q_bc = {32'h0000_0040, 32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
        q_wr = {4{32'hDEAD_BEEF}};
        q_wc = {4{32'h1234_5678}};
        one_txn(lat);
        check("t6_latency", 128'(lat), 128'd3);
        check("t6_main_cr", {96'b0, cr}, {96'b0, 32'h0002_0000});
        check("t6_quad_val", {127'b0, q_send_val}, 128'd1);
        check("t6_quad_cr", q_cr, {32'h7FFF_FFFF, 32'h0003_0300, 32'h0002_0200, 32'h0001_0100});
        check("t6_quad_cc", q_cc, {32'h0000_4040, 32'h0000_3030, 32'h0000_2020, 32'h0000_1010});
        check("t6_quad_dr", q_dr, {32'h7FFF_FBFF, 32'h0002_FD00, 32'h0001_FE00, 32'h0000_FF00});
        check("t6_quad_dc", q_dc, {32'h0000_3FC0, 32'h0000_2FD0, 32'h0000_1FE0, 32'h0000_0FF0});
        check("t6_quad_ovf", {124'b0, q_ovf}, 128'h8);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
